// File: rtl/gate_pkg.sv
// Shared types and constants for the parking-gate sensor decoder.
// Holds the direction FSM state encoding and the {a,b} sensor code values.
package gate_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E1    = 3'd1,
        ST_E2    = 3'd2,
        ST_E3    = 3'd3,
        ST_X1    = 3'd4,
        ST_X2    = 3'd5,
        ST_X3    = 3'd6,
        ST_FAULT = 3'd7
    } state_t;

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_A    = 2'b10;
    localparam logic [1:0] CODE_B    = 2'b01;
    localparam logic [1:0] CODE_AB   = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Single-sensor debouncer: the filtered value follows the raw input only after
// DEB_CYCLES consecutive edges on which the raw sample disagrees with it.
module sensor_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic filt
);

    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // Any agreeing sample restarts the run of disagreeing edges.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (raw != filt_q) begin
            if (cnt_q == DW'(DEB_CYCLES - 1)) begin
                filt_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/gate_sensor_decoder.sv
// Lane beam-sensor front end: debounce A/B, track crossing order, emit ent/ext pulses.
// Optional build macro SENSOR_SYNC_EN adds a 2-flop synchronizer on each raw sensor.
module gate_sensor_decoder
    import gate_pkg::*;
#(
    parameter int DEB_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic clr,
    input  logic sens_a,
    input  logic sens_b,
    output logic ent,
    output logic ext,
    output logic busy,
    output logic fault,
    output logic a_filt,
    output logic b_filt
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic a_raw, b_raw;

`ifdef SENSOR_SYNC_EN
    logic [1:0] sync_a_q, sync_a_d, sync_b_q, sync_b_d;

    always_comb begin
        sync_a_d = {sync_a_q[0], sens_a};
        sync_b_d = {sync_b_q[0], sens_b};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
        end
    end

    assign a_raw = sync_a_q[1];
    assign b_raw = sync_b_q[1];
`else
    assign a_raw = sens_a;
    assign b_raw = sens_b;
`endif

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk  (clk),
        .clr  (clr),
        .raw  (a_raw),
        .filt (a_filt)
    );

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk  (clk),
        .clr  (clr),
        .raw  (b_raw),
        .filt (b_filt)
    );

    logic [1:0]       code;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             ent_q, ent_d, ext_q, ext_d;
    logic             busy_q, busy_d, fault_q, fault_d;

    assign code = {a_filt, b_filt};

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        ent_d   = 1'b0;
        ext_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                case (code)
                    CODE_A:  state_d = ST_E1;
                    CODE_B:  state_d = ST_X1;
                    CODE_AB: state_d = ST_FAULT;
                    default: state_d = ST_IDLE;
                endcase
            end
            ST_E1: begin
                case (code)
                    CODE_AB:   state_d = ST_E2;
                    CODE_NONE: state_d = ST_IDLE;
                    CODE_B:    state_d = ST_FAULT;
                    default:   state_d = ST_E1;
                endcase
            end
            ST_E2: begin
                case (code)
                    CODE_B:    state_d = ST_E3;
                    CODE_A:    state_d = ST_E1;
                    CODE_NONE: state_d = ST_FAULT;
                    default:   state_d = ST_E2;
                endcase
            end
            ST_E3: begin
                case (code)
                    CODE_NONE: begin
                        state_d = ST_IDLE;
                        ent_d   = 1'b1;
                    end
                    CODE_AB: state_d = ST_E2;
                    CODE_A:  state_d = ST_FAULT;
                    default: state_d = ST_E3;
                endcase
            end
            ST_X1: begin
                case (code)
                    CODE_AB:   state_d = ST_X2;
                    CODE_NONE: state_d = ST_IDLE;
                    CODE_A:    state_d = ST_FAULT;
                    default:   state_d = ST_X1;
                endcase
            end
            ST_X2: begin
                case (code)
                    CODE_A:    state_d = ST_X3;
                    CODE_B:    state_d = ST_X1;
                    CODE_NONE: state_d = ST_FAULT;
                    default:   state_d = ST_X2;
                endcase
            end
            ST_X3: begin
                case (code)
                    CODE_NONE: begin
                        state_d = ST_IDLE;
                        ext_d   = 1'b1;
                    end
                    CODE_AB: state_d = ST_X2;
                    CODE_B:  state_d = ST_FAULT;
                    default: state_d = ST_X3;
                endcase
            end
            default: begin
                if (code == CODE_NONE) state_d = ST_IDLE;
            end
        endcase

        // A stalled crossing counts up while it holds; a completed count forces FAULT.
        if (state_q != ST_IDLE && state_q != ST_FAULT && state_d == state_q) begin
            if (tmo_q == CNT_W'(TIMEOUT_CYCLES)) begin
                state_d = ST_FAULT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        busy_d  = (state_d != ST_IDLE);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            ent_q   <= 1'b0;
            ext_q   <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            ent_q   <= ent_d;
            ext_q   <= ext_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign ent   = ent_q;
    assign ext   = ext_q;
    assign busy  = busy_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed bench for gate_sensor_decoder with DEB_CYCLES=4 and TIMEOUT_CYCLES=16.
module tb_gate_sensor_decoder;

`ifdef SENSOR_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic clk, clr, sens_a, sens_b;
    logic ent, ext, busy, fault, a_filt, b_filt;

    int n_checks = 0;
    int n_fail   = 0;
    int ent_cnt = 0, ext_cnt = 0, fault_cnt = 0, busy_cnt = 0, af_cnt = 0, both_cnt = 0;

    gate_sensor_decoder #(.DEB_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .clr    (clr),
        .sens_a (sens_a),
        .sens_b (sens_b),
        .ent    (ent),
        .ext    (ext),
        .busy   (busy),
        .fault  (fault),
        .a_filt (a_filt),
        .b_filt (b_filt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ent) ent_cnt++;
        if (ext) ext_cnt++;
        if (fault) fault_cnt++;
        if (busy) busy_cnt++;
        if (a_filt) af_cnt++;
        if (ent && ext) both_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input int n);
        sens_a = a;
        sens_b = b;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return ent;
            1:       return ext;
            2:       return fault;
            default: return !fault;
        endcase
    endfunction

    task automatic find_first(input int sel, input int maxk, output int k);
        k = -1;
        for (int i = 1; i <= maxk; i++) begin
            @(negedge clk);
            if (k < 0 && pick(sel)) k = i;
        end
    endtask

    int k, e0, x0, f0, b0, a0;

    task automatic snap();
        e0 = ent_cnt; x0 = ext_cnt; f0 = fault_cnt; b0 = busy_cnt; a0 = af_cnt;
    endtask

    initial begin
        clr = 1'b1; sens_a = 1'b0; sens_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ent", ent, 0);
        chk("rst_ext", ext, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_afilt", a_filt, 0);
        chk("rst_bfilt", b_filt, 0);
        clr = 1'b0;
        drive(0, 0, 4);

        // clean entry
        snap();
        drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10);
        sens_a = 0; sens_b = 0;
        find_first(0, 15, k);
        chk("entry_latency", k, 5 + SYNC);
        chk("entry_ent_cnt", ent_cnt - e0, 1);
        chk("entry_ext_cnt", ext_cnt - x0, 0);
        chk("entry_fault", fault_cnt - f0, 0);
        chk("entry_busy_end", busy, 0);

        // clean exit
        snap();
        drive(0, 1, 10); drive(1, 1, 10); drive(1, 0, 10);
        sens_a = 0; sens_b = 0;
        find_first(1, 15, k);
        chk("exit_latency", k, 5 + SYNC);
        chk("exit_ext_cnt", ext_cnt - x0, 1);
        chk("exit_ent_cnt", ent_cnt - e0, 0);
        chk("exit_fault", fault_cnt - f0, 0);

        // glitches shorter than the debounce window
        snap();
        for (int g = 0; g < 3; g++) begin
            drive(1, 0, 3);
            drive(0, 0, 5);
        end
        drive(0, 0, 4);
        chk("glitch_afilt", af_cnt - a0, 0);
        chk("glitch_busy", busy_cnt - b0, 0);
        chk("glitch_pulses", (ent_cnt - e0) + (ext_cnt - x0), 0);

        // back-out before completing entry
        snap();
        drive(1, 0, 10); drive(1, 1, 10); drive(1, 0, 10); drive(0, 0, 12);
        chk("backout_busy", busy, 0);
        chk("backout_pulses", (ent_cnt - e0) + (ext_cnt - x0), 0);
        chk("backout_fault", fault_cnt - f0, 0);

        // stuck in E2 until timeout, then recover through 00
        snap();
        drive(1, 0, 10);
        sens_a = 1; sens_b = 1;
        find_first(2, 30, k);
        chk("timeout_fault_at", k, 22 + SYNC);
        chk("timeout_busy", busy, 1);
        sens_a = 0; sens_b = 0;
        find_first(3, 10, k);
        chk("fault_clear_at", k, 5 + SYNC);
        chk("fault_busy_end", busy, 0);
        chk("timeout_pulses", (ent_cnt - e0) + (ext_cnt - x0), 0);

        // clr in E3 aborts the crossing silently
        snap();
        drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10);
        chk("e3_busy_before_clr", busy, 1);
        clr = 1'b1; sens_a = 0; sens_b = 0;
        @(negedge clk);
        chk("clr_busy", busy, 0);
        chk("clr_afilt", a_filt, 0);
        chk("clr_bfilt", b_filt, 0);
        chk("clr_fault", fault, 0);
        clr = 1'b0;
        drive(0, 0, 10);
        chk("clr_no_ent", ent_cnt - e0, 0);
        drive(1, 0, 10); drive(1, 1, 10); drive(0, 1, 10); drive(0, 0, 12);
        chk("post_clr_ent", ent_cnt - e0, 1);
        chk("post_clr_ext", ext_cnt - x0, 0);

        chk("never_both", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
